tv_checker: RTL and testbench

- Parametrised, synthesizable test-vector sequencer and checker for CPU-class DUTs.
- Holds DEPTH stimulus/expected/mask vectors in internal memory and replays one vector per clock into the DUT.
- Compares DUT outputs a fixed number of cycles later under a don't-care mask.
- Reports error count, first failing index and pass/done status; replaces per-DUT hand-written vector benches.

---
 rtl/tv_checker_if.sv | 50 +++++
 rtl/tv_checker.sv | 215 +++++++++++++++++++++
 tb/tb_tv_checker.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tv_checker_if.sv
// tv_checker_if: bundles the vector-load bus, run control, DUT-facing
// stimulus/observation signals and the result/status outputs of tv_checker.
//   master : testbench / host side (loads vectors, starts runs, drives dut_out)
//   slave  : tv_checker side
// Parameters mirror tv_checker: IN_W, OUT_W, DEPTH, ERR_W.
interface tv_checker_if #(
    parameter int unsigned IN_W  = 33,
    parameter int unsigned OUT_W = 49,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned ERR_W = 16
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned LD_W   = IN_W + 2 * OUT_W;

    // vector load and run control
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [LD_W-1:0]   ld_data;
    logic [CNT_W-1:0]  num_vec;
    logic              start;

    // DUT-facing
    logic [IN_W-1:0]   stim_out;
    logic              stim_valid;
    logic [OUT_W-1:0]  dut_out;

    // status and results
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  vec_cnt;
    logic              fail_seen;
    logic [ADDR_W-1:0] first_fail_idx;
    logic [OUT_W-1:0]  first_fail_obs;
    logic [OUT_W-1:0]  first_fail_exp;

    modport master (
        output ld_en, ld_addr, ld_data, num_vec, start, dut_out,
        input  stim_out, stim_valid, busy, done, pass, err_cnt, vec_cnt,
               fail_seen, first_fail_idx, first_fail_obs, first_fail_exp
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, num_vec, start, dut_out,
        output stim_out, stim_valid, busy, done, pass, err_cnt, vec_cnt,
               fail_seen, first_fail_idx, first_fail_obs, first_fail_exp
    );
endinterface

// File: rtl/tv_checker.sv
// tv_checker: test-vector sequencer and checker. Holds DEPTH {stim, exp, mask}
// vectors, replays one stimulus per clock into a DUT and compares the DUT
// outputs LAT edges later under a don't-care mask.
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - synchronous active-high reset
//   bus.slave  - load bus (ld_en/ld_addr/ld_data), run control (num_vec/start),
//                DUT stimulus (stim_out/stim_valid) and observation (dut_out),
//                status/results (busy, done, pass, err_cnt, vec_cnt, fail_seen,
//                first_fail_idx, first_fail_obs, first_fail_exp)
// Optional feature: define TVC_FIRST_FAIL_CAPTURE_EN to capture the observed and
// expected values of the first mismatch; otherwise those ports are tied to 0.
module tv_checker #(
    parameter int unsigned IN_W  = 33,
    parameter int unsigned OUT_W = 49,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LAT   = 1,
    parameter int unsigned ERR_W = 16
) (
    input logic         clk,
    input logic         rst,
    tv_checker_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned LD_W   = IN_W + 2 * OUT_W;
    localparam int unsigned DRN_W  = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // one in-flight vector awaiting its DUT response
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] idx;
        logic [OUT_W-1:0]  exp;
        logic [OUT_W-1:0]  mask;
    } pipe_t;

    logic [LD_W-1:0]   mem [DEPTH];

    state_t            state;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  n_run_q;
    logic [DRN_W-1:0]  drain_cnt_q;
    pipe_t             pipe [LAT];

    logic [IN_W-1:0]   stim_q;
    logic              stim_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [CNT_W-1:0]  vec_cnt_q;
    logic              fail_seen_q;
    logic [ADDR_W-1:0] first_fail_idx_q;

    logic [LD_W-1:0]   rd_c;
    logic [IN_W-1:0]   stim_c;
    logic [OUT_W-1:0]  exp_c;
    logic [OUT_W-1:0]  mask_c;
    pipe_t             head_c;
    logic              active_c;
    logic              chk_c;
    logic              mis_c;
    logic              first_mis_c;
    logic              start_acc_c;
    logic [CNT_W-1:0]  n_clamp_c;

    // vector memory: written only while no run is in progress, never cleared
    always_ff @(posedge clk) begin
        if (bus.ld_en && !busy_q) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    // current vector fields and compare of the oldest in-flight vector
    always_comb begin
        rd_c        = mem[idx_q[ADDR_W-1:0]];
        stim_c      = rd_c[LD_W-1 -: IN_W];
        exp_c       = rd_c[2*OUT_W-1 -: OUT_W];
        mask_c      = rd_c[OUT_W-1:0];
        head_c      = pipe[LAT-1];
        active_c    = (state == RUN) || (state == DRAIN);
        chk_c       = active_c && head_c.valid;
        mis_c       = chk_c && (|((bus.dut_out ^ head_c.exp) & head_c.mask));
        first_mis_c = mis_c && !fail_seen_q;
        start_acc_c = bus.start && ((state == IDLE) || (state == DONE));
        n_clamp_c   = (bus.num_vec > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.num_vec;
    end

    // run sequencer, response pipeline and result bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx_q            <= '0;
            n_run_q          <= '0;
            drain_cnt_q      <= '0;
            stim_q           <= '0;
            stim_valid_q     <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_cnt_q        <= '0;
            vec_cnt_q        <= '0;
            fail_seen_q      <= 1'b0;
            first_fail_idx_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            // pipeline advances every RUN/DRAIN edge; DRAIN pushes bubbles
            if (active_c) begin
                for (int i = int'(LAT) - 1; i > 0; i--) begin
                    pipe[i] <= pipe[i-1];
                end
                if (state == RUN) begin
                    pipe[0].valid <= 1'b1;
                    pipe[0].idx   <= idx_q[ADDR_W-1:0];
                    pipe[0].exp   <= exp_c;
                    pipe[0].mask  <= mask_c;
                end else begin
                    pipe[0] <= '0;
                end
                if (chk_c) begin
                    vec_cnt_q <= vec_cnt_q + CNT_W'(1);
                end
                if (mis_c && !(&err_cnt_q)) begin
                    err_cnt_q <= err_cnt_q + ERR_W'(1);
                end
                if (first_mis_c) begin
                    fail_seen_q      <= 1'b1;
                    first_fail_idx_q <= head_c.idx;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        idx_q            <= '0;
                        n_run_q          <= n_clamp_c;
                        err_cnt_q        <= '0;
                        vec_cnt_q        <= '0;
                        fail_seen_q      <= 1'b0;
                        first_fail_idx_q <= '0;
                        if (n_clamp_c == '0) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                            pass_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    stim_q       <= stim_c;
                    stim_valid_q <= 1'b1;
                    idx_q        <= idx_q + CNT_W'(1);
                    if (idx_q == n_run_q - CNT_W'(1)) begin
                        state       <= DRAIN;
                        drain_cnt_q <= DRN_W'(LAT - 1);
                    end
                end
                DRAIN: begin
                    stim_valid_q <= 1'b0;
                    if (drain_cnt_q == '0) begin
                        // last response is checked on this same edge
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_cnt_q == '0) && !mis_c;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DRN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TVC_FIRST_FAIL_CAPTURE_EN
    logic [OUT_W-1:0] first_fail_obs_q;
    logic [OUT_W-1:0] first_fail_exp_q;

    // snapshot of the first mismatching response
    always_ff @(posedge clk) begin
        if (rst || start_acc_c) begin
            first_fail_obs_q <= '0;
            first_fail_exp_q <= '0;
        end else if (first_mis_c) begin
            first_fail_obs_q <= bus.dut_out;
            first_fail_exp_q <= head_c.exp;
        end
    end

    assign bus.first_fail_obs = first_fail_obs_q;
    assign bus.first_fail_exp = first_fail_exp_q;
`else
    assign bus.first_fail_obs = '0;
    assign bus.first_fail_exp = '0;
`endif

    assign bus.stim_out       = stim_q;
    assign bus.stim_valid     = stim_valid_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_cnt        = err_cnt_q;
    assign bus.vec_cnt        = vec_cnt_q;
    assign bus.fail_seen      = fail_seen_q;
    assign bus.first_fail_idx = first_fail_idx_q;
endmodule

// File: tb/tb_tv_checker.sv
// tb_tv_checker: scoreboard bench for tv_checker with a combinational
// DUT model (dut_out = stim_out + 1), IN_W=OUT_W=8, LAT=1, DEPTH=16, ERR_W=2.
// Expected stimulus bytes and per-run results are queued at launch time and
// popped by an independent monitor whenever the checker presents them.
module tb_tv_checker;
    localparam int unsigned IN_W    = 8;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned LAT     = 1;
    localparam int unsigned ERR_W   = 2;
    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int          ERR_MAX = (1 << ERR_W) - 1;

    typedef struct {
        int vcnt;
        int ecnt;
        int fseen;
        int fidx;
        int pss;
        int obs;
        int expv;
        int done_cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] m_stim [DEPTH];
    logic [7:0] m_exp  [DEPTH];
    logic [7:0] m_mask [DEPTH];
    logic [7:0] stim_q [$];
    res_t       res_q  [$];

    tv_checker_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ERR_W(ERR_W)) bus ();

    tv_checker #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LAT(LAT), .ERR_W(ERR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // the device being checked: a combinational incrementer
    assign bus.dut_out = bus.stim_out + 8'd1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // reference: outcome of replaying vectors 0..n-1 against stim+1
    function automatic res_t model(input int n_in, input int s);
        int         n;
        res_t       r;
        logic [7:0] obs;
        n = (n_in > int'(DEPTH)) ? int'(DEPTH) : n_in;
        r = '{default: 0};
        r.vcnt = n;
        r.pss  = 1;
        for (int i = 0; i < n; i++) begin
            obs = m_stim[i] + 8'd1;
            if (((obs ^ m_exp[i]) & m_mask[i]) != 8'h00) begin
                if (r.ecnt < ERR_MAX) r.ecnt++;
                r.pss = 0;
                if (r.fseen == 0) begin
                    r.fseen = 1;
                    r.fidx  = i;
`ifdef TVC_FIRST_FAIL_CAPTURE_EN
                    r.obs  = int'(obs);
                    r.expv = int'(m_exp[i]);
`endif
                end
            end
        end
        r.done_cyc = s + ((n == 0) ? 1 : n + 1 + int'(LAT));
        return r;
    endfunction

    task automatic load(input int a, input logic [7:0] s, input logic [7:0] e,
                        input logic [7:0] m);
        @(negedge clk);
        bus.ld_en   = 1'b1;
        bus.ld_addr = ADDR_W'(a);
        bus.ld_data = {s, e, m};
        m_stim[a] = s;
        m_exp[a]  = e;
        m_mask[a] = m;
        @(negedge clk);
        bus.ld_en = 1'b0;
    endtask

    task automatic load_random(input int a);
        logic [7:0] s, e, m;
        s = 8'($urandom);
        m = 8'($urandom);
        e = ($urandom_range(0, 3) == 0) ? 8'($urandom) : s + 8'd1;
        load(a, s, e, m);
    endtask

    // queue expectations, then pulse start; returns one edge after the start edge
    task automatic launch(input int n);
        int nc;
        @(negedge clk);
        bus.num_vec = CNT_W'(n);
        bus.start   = 1'b1;
        nc = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        for (int i = 0; i < nc; i++) stim_q.push_back(m_stim[i]);
        res_q.push_back(model(n, cyc));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (res_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (res_q.size() != 0) begin
            flag("timeout waiting for done");
            res_q.delete();
            stim_q.delete();
        end
        check("stim_leftover", stim_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stim_out"},   int'(bus.stim_out), 0);
        check({tag, "_stim_valid"}, int'(bus.stim_valid), 0);
        check({tag, "_busy"},       int'(bus.busy), 0);
        check({tag, "_done"},       int'(bus.done), 0);
        check({tag, "_pass"},       int'(bus.pass), 0);
        check({tag, "_err_cnt"},    int'(bus.err_cnt), 0);
        check({tag, "_vec_cnt"},    int'(bus.vec_cnt), 0);
        check({tag, "_fail_seen"},  int'(bus.fail_seen), 0);
        check({tag, "_ff_idx"},     int'(bus.first_fail_idx), 0);
        check({tag, "_ff_obs"},     int'(bus.first_fail_obs), 0);
        check({tag, "_ff_exp"},     int'(bus.first_fail_exp), 0);
    endtask

    // monitor: pops expectations whenever the checker presents a stimulus or completes
    initial begin : monitor
        logic done_prev;
        res_t r;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.stim_valid) begin
                if (stim_q.size() == 0) flag("unexpected stim_valid");
                else check("stim_out", int'(bus.stim_out), int'(stim_q.pop_front()));
            end
            if (bus.done && !done_prev) begin
                if (res_q.size() == 0) begin
                    flag("unexpected done");
                end else begin
                    r = res_q.pop_front();
                    check("done_cycle", cyc, r.done_cyc);
                    check("vec_cnt",    int'(bus.vec_cnt), r.vcnt);
                    check("err_cnt",    int'(bus.err_cnt), r.ecnt);
                    check("fail_seen",  int'(bus.fail_seen), r.fseen);
                    check("ff_idx",     int'(bus.first_fail_idx), r.fidx);
                    check("pass",       int'(bus.pass), r.pss);
                    check("ff_obs",     int'(bus.first_fail_obs), r.obs);
                    check("ff_exp",     int'(bus.first_fail_exp), r.expv);
                    check("busy_at_done", int'(bus.busy), 0);
                end
            end
            done_prev = bus.done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation did not complete");
    end

    initial begin : stimulus
        bus.ld_en   = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        bus.num_vec = '0;
        bus.start   = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // clean run
        for (int i = 0; i < 4; i++) load(i, 8'h10 + 8'(i), 8'h11 + 8'(i), 8'hFF);
        launch(4);
        wait_done();

        // error on vector 2, then the same error hidden by the mask
        load(2, 8'h12, 8'h5F, 8'hFF);
        launch(4);
        wait_done();
        load(2, 8'h12, 8'h5F, 8'hA0);
        launch(4);
        wait_done();
        load(2, 8'h12, 8'h13, 8'hFF);

        // start and load while running must be ignored
        launch(4);
        bus.start   = 1'b1;
        bus.num_vec = CNT_W'(2);
        bus.ld_en   = 1'b1;
        bus.ld_addr = ADDR_W'(3);
        bus.ld_data = 24'hAA00FF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.ld_en = 1'b0;
        wait_done();

        // reset on the third RUN edge, then restart from retained memory
        launch(4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrst");
        stim_q.delete();
        res_q.delete();
        launch(4);
        wait_done();

        // five failures saturate a 2-bit error counter
        for (int i = 0; i < 5; i++) load(i, 8'(i), 8'h80, 8'hFF);
        launch(5);
        wait_done();

        // empty run from IDLE
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        launch(0);
        wait_done();

        // oversized request is clamped to DEPTH
        for (int i = 0; i < int'(DEPTH); i++) load_random(i);
        launch(int'(DEPTH) + 5);
        wait_done();

        // randomized runs
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < int'(DEPTH); i++) load_random(i);
            launch(int'($urandom_range(1, int'(DEPTH) + 4)));
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
